// File: rtl/cqpic_pkg.sv
// Shared CQPIC definitions: program ROM geometry, the owner tag that
// routes a ROM read back to its requester, and the debug burst states.
package cqpic_pkg;

  localparam int ROM_ADDR_W = 13;
  localparam int ROM_DATA_W = 14;

  // Which requester owns the ROM word arriving on the next cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DBG   = 2'd2
  } owner_e;

  // Debug burst sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } dbg_state_e;

endpackage

// File: rtl/rom_dbg_burst.sv
// Debug burst sequencer: latches a start address and length, then walks
// the ROM address space one word per granted slot. The address wraps at
// the top of the ROM. DRAIN covers the cycle in which the final word
// returns from the ROM.
//
// Handshake: req_o is high for the whole of ACTIVE and addr_o is the word
// it wants. The arbiter raises issue_i in a cycle where it drives addr_o
// onto the ROM; every cycle with req_o && issue_i consumes exactly one
// word. issue_i is ignored outside ACTIVE.
module rom_dbg_burst
  import cqpic_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              ponrst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [LEN_W-1:0]  start_len_i,
  input  logic              issue_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  output dbg_state_e        state_o
);

  dbg_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;

  // State, address and remaining-count registers; reset aborts any burst.
  always_ff @(posedge clk or negedge ponrst_n) begin
    if (!ponrst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic; rem_q holds words still to issue minus one.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = start_addr_i;
          rem_d   = start_len_i;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (issue_i) begin
          addr_d = addr_q + ADDR_W'(1);
          if (rem_q == '0) begin
            state_d = DRAIN;
          end else begin
            rem_d = rem_q - LEN_W'(1);
          end
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_o   = (state_q == ACTIVE);
  assign addr_o  = addr_q;
  assign state_o = state_q;

endmodule

// File: rtl/prog_rom_arbiter.sv
// Program ROM arbiter: shares the single-port, one-cycle-latency program
// ROM between CPU instruction fetch (fixed priority) and the debug
// burst-readback port. After MAX_WAIT consecutive lost cycles the debug
// port is granted one slot. Read data is steered back using an owner tag
// registered at issue time.
//
// Optional build macro ROMARB_ACCESS_COUNT_EN adds free-running 16-bit
// counters of issued fetches, issued debug words and fetch stall cycles.
module prog_rom_arbiter
  import cqpic_pkg::*;
#(
  parameter int ADDR_W   = ROM_ADDR_W,
  parameter int DATA_W   = ROM_DATA_W,
  parameter int MAX_WAIT = 4,
  parameter int LEN_W    = 8
) (
  input  logic              clk,
  input  logic              ponrst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_stall,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              dbg_start,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [LEN_W-1:0]  dbg_len,
  output logic              dbg_busy,
  output logic              dbg_valid,
  output logic [DATA_W-1:0] dbg_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
`ifdef ROMARB_ACCESS_COUNT_EN
  ,
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       dbg_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic              burst_req;
  logic [ADDR_W-1:0] burst_addr;
  dbg_state_e        burst_state;

  logic              dbg_win;
  logic              fetch_win;
  logic [3:0]        wait_q, wait_d;
  owner_e            own_q, own_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [DATA_W-1:0] fetch_hold_q;
  logic [DATA_W-1:0] dbg_hold_q;

  rom_dbg_burst #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_burst (
    .clk          (clk),
    .ponrst_n     (ponrst_n),
    .start_i      (dbg_start),
    .start_addr_i (dbg_addr),
    .start_len_i  (dbg_len),
    .issue_i      (dbg_win),
    .req_o        (burst_req),
    .addr_o       (burst_addr),
    .state_o      (burst_state)
  );

  // Per-cycle arbitration, ROM address mux and starvation counter update.
  always_comb begin
    dbg_win     = burst_req && (!fetch_req || (wait_q == WAIT_MAX));
    fetch_win   = fetch_req && !dbg_win;
    fetch_stall = fetch_req && dbg_win;
    own_d       = OWN_NONE;
    last_addr_d = last_addr_q;
    wait_d      = '0;
    if (dbg_win) begin
      rom_addr = burst_addr;
      own_d    = OWN_DBG;
    end else if (fetch_win) begin
      rom_addr = fetch_addr;
      own_d    = OWN_FETCH;
    end else begin
      // Park on the last issued address so the ROM address bus stays quiet.
      rom_addr = last_addr_q;
    end
    if (dbg_win || fetch_win) begin
      last_addr_d = rom_addr;
    end
    if (burst_req && !dbg_win) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 4'd1;
    end
  end

  // Arbitration state: owner tag of the in-flight read, parked address, wait count.
  always_ff @(posedge clk or negedge ponrst_n) begin
    if (!ponrst_n) begin
      own_q       <= OWN_NONE;
      last_addr_q <= '0;
      wait_q      <= '0;
    end else begin
      own_q       <= own_d;
      last_addr_q <= last_addr_d;
      wait_q      <= wait_d;
    end
  end

  assign fetch_valid = (own_q == OWN_FETCH);
  assign dbg_valid   = (own_q == OWN_DBG);
  assign dbg_busy    = (burst_state != IDLE);

  // Data outputs pass the ROM word through while valid and hold it afterwards.
  assign fetch_data = fetch_valid ? rom_data : fetch_hold_q;
  assign dbg_data   = dbg_valid ? rom_data : dbg_hold_q;

  // Capture returned words so the data outputs hold between valids.
  always_ff @(posedge clk or negedge ponrst_n) begin
    if (!ponrst_n) begin
      fetch_hold_q <= '0;
      dbg_hold_q   <= '0;
    end else begin
      if (fetch_valid) fetch_hold_q <= rom_data;
      if (dbg_valid)   dbg_hold_q   <= rom_data;
    end
  end

`ifdef ROMARB_ACCESS_COUNT_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] dbg_cnt_q;
  logic [15:0] stall_cnt_q;

  // Wrapping access counters for ROM bandwidth profiling.
  always_ff @(posedge clk or negedge ponrst_n) begin
    if (!ponrst_n) begin
      fetch_cnt_q <= '0;
      dbg_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fetch_win)   fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (dbg_win)     dbg_cnt_q   <= dbg_cnt_q + 16'd1;
      if (fetch_stall) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign dbg_cnt   = dbg_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_prog_rom_arbiter.sv
// Testbench for prog_rom_arbiter. A behavioural ROM sits on rom_addr /
// rom_data. The reference model tracks the debug burst as a queue of
// pending addresses, a loss counter and the word owed on the next cycle,
// and predicts every DUT output each cycle.
module tb_prog_rom_arbiter;

  localparam int ADDR_W   = 13;
  localparam int DATA_W   = 14;
  localparam int MAX_WAIT = 4;
  localparam int LEN_W    = 8;

  logic              clk;
  logic              ponrst_n;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_stall;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              dbg_start;
  logic [ADDR_W-1:0] dbg_addr;
  logic [LEN_W-1:0]  dbg_len;
  logic              dbg_busy;
  logic              dbg_valid;
  logic [DATA_W-1:0] dbg_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
`ifdef ROMARB_ACCESS_COUNT_EN
  logic [15:0]       fetch_cnt;
  logic [15:0]       dbg_cnt;
  logic [15:0]       stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  prog_rom_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT),
    .LEN_W    (LEN_W)
  ) dut (
    .clk         (clk),
    .ponrst_n    (ponrst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_stall (fetch_stall),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .dbg_start   (dbg_start),
    .dbg_addr    (dbg_addr),
    .dbg_len     (dbg_len),
    .dbg_busy    (dbg_busy),
    .dbg_valid   (dbg_valid),
    .dbg_data    (dbg_data),
    .rom_addr    (rom_addr),
    .rom_data    (rom_q)
`ifdef ROMARB_ACCESS_COUNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .dbg_cnt     (dbg_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  // ---------------- clock / ROM ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] rom_mem [0:8191];
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [ADDR_W-1:0] m_words[$];   // debug addresses still to issue
  logic [DATA_W-1:0] exp_q[$];     // debug words expected, in order
  int                m_losses;
  bit                m_drain;
  int                m_pend_own;   // 0 none, 1 fetch, 2 debug
  logic [DATA_W-1:0] m_pend_data;
  logic [ADDR_W-1:0] m_last;
  logic [DATA_W-1:0] m_fhold, m_dhold;
  logic [15:0]       m_fcnt, m_dcnt, m_scnt;

  logic [ADDR_W-1:0] e_addr;
  logic              e_stall, e_fv, e_busy, e_dv;
  logic [DATA_W-1:0] e_fd, e_dd;

  task automatic m_reset();
    m_words.delete();
    exp_q.delete();
    m_losses = 0; m_drain = 0; m_pend_own = 0; m_pend_data = '0;
    m_last = '0; m_fhold = '0; m_dhold = '0;
    m_fcnt = '0; m_dcnt = '0; m_scnt = '0;
  endtask

  function automatic bit m_idle();
    return (m_words.size() == 0) && !m_drain;
  endfunction

  task automatic m_cycle(input bit fr, input logic [ADDR_W-1:0] fa, input bit ds,
                         input logic [ADDR_W-1:0] da, input logic [LEN_W-1:0] dl);
    bit active, dwin, fwin;
    active  = (m_words.size() != 0);
    e_busy  = active || m_drain;
    dwin    = active && (!fr || m_losses == MAX_WAIT);
    fwin    = fr && !dwin;
    e_fv    = (m_pend_own == 1);
    e_dv    = (m_pend_own == 2);
    e_fd    = e_fv ? m_pend_data : m_fhold;
    e_dd    = e_dv ? m_pend_data : m_dhold;
    e_addr  = dwin ? m_words[0] : (fwin ? fa : m_last);
    e_stall = fr && dwin;
    m_fhold = e_fd;
    m_dhold = e_dd;
    if (dwin) begin
      m_pend_own = 2; m_pend_data = exp_q.pop_front();
    end else if (fwin) begin
      m_pend_own = 1; m_pend_data = rom_mem[fa];
    end else begin
      m_pend_own = 0;
    end
    if (dwin || fwin) m_last = e_addr;
    m_drain = dwin && (m_words.size() == 1);
    if (dwin) m_words.delete(0);
    if (active && !dwin) m_losses = (m_losses < MAX_WAIT) ? m_losses + 1 : MAX_WAIT;
    else m_losses = 0;
    if (ds && !e_busy) begin
      for (int i = 0; i <= int'(dl); i++) begin
        m_words.push_back(da + ADDR_W'(i));
        exp_q.push_back(rom_mem[da + ADDR_W'(i)]);
      end
    end
    if (fwin)    m_fcnt = m_fcnt + 16'd1;
    if (dwin)    m_dcnt = m_dcnt + 16'd1;
    if (e_stall) m_scnt = m_scnt + 16'd1;
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit fr, input logic [ADDR_W-1:0] fa, input bit ds,
                      input logic [ADDR_W-1:0] da, input logic [LEN_W-1:0] dl);
    @(posedge clk); #1;
    fetch_req = fr; fetch_addr = fa; dbg_start = ds; dbg_addr = da; dbg_len = dl;
    m_cycle(fr, fa, ds, da, dl);
    @(negedge clk);
  endtask

  function automatic logic [44:0] obs_vec();
    return {rom_addr, fetch_stall, fetch_valid, fetch_data, dbg_busy, dbg_valid, dbg_data};
  endfunction

  function automatic logic [44:0] exp_vec();
    return {e_addr, e_stall, e_fv, e_fd, e_busy, e_dv, e_dd};
  endfunction

  function automatic string fmt(input logic [44:0] v);
    return $sformatf("addr=%h st=%b fv=%b fd=%h busy=%b dv=%b dd=%h",
                     v[44:32], v[31], v[30], v[29:16], v[15], v[14], v[13:0]);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    fetch_req = 0; fetch_addr = '0; dbg_start = 0; dbg_addr = '0; dbg_len = '0;
    ponrst_n = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 45'd0) begin
      errors++;
      $display("FAIL reset_values: got %s, expected all zero", fmt(obs_vec()));
    end
    repeat (2) @(posedge clk);
    #2 ponrst_n = 1'b1;
    m_reset();
    for (int c = 0; c < 2; c++) begin
      step(0, ADDR_W'($urandom), 0, '0, '0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %s, expected %s", c, fmt(obs_vec()), fmt(exp_vec()));
      end
    end
  endtask

  task automatic test_fetch_only();
    for (int c = 0; c < 6; c++) begin
      step(c < 4, ADDR_W'(c < 4 ? c : 0), 0, '0, '0);
      checks++;
      if (obs_vec() !== exp_vec() || fetch_stall !== 1'b0) begin
        errors++;
        $display("FAIL fetch_only cyc %0d: got %s, expected %s", c, fmt(obs_vec()), fmt(exp_vec()));
      end
    end
  endtask

  task automatic test_dbg_wrap();
    int pulses = 0, last_dv = -1, busy_fall = -1;
    step(0, '0, 1, 13'h1FFE, 8'd3);
    for (int c = 1; c < 10; c++) begin
      step(0, '0, 0, '0, '0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL dbg_wrap cyc %0d: got %s, expected %s", c, fmt(obs_vec()), fmt(exp_vec()));
      end
      if (dbg_valid === 1'b1) begin pulses++; last_dv = c; end
      if (dbg_busy === 1'b0 && busy_fall < 0) busy_fall = c;
    end
    checks++;
    if (pulses != 4 || busy_fall != last_dv + 1) begin
      errors++;
      $display("FAIL dbg_wrap_pulses: got %0d pulses busy_fall=%0d last_dv=%0d, expected 4 pulses busy_fall=last_dv+1",
               pulses, busy_fall, last_dv);
    end
  endtask

  task automatic test_starvation();
    logic [LEN_W-1:0] len;
    int stalls = 0;
    bit done = 0;
    len = LEN_W'($urandom_range(4, 9));
    step(1, ADDR_W'($urandom), 1, ADDR_W'($urandom), len);
    for (int c = 1; c < 80; c++) begin
      step(1, ADDR_W'($urandom), 0, '0, '0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL starvation cyc %0d: got %s, expected %s", c, fmt(obs_vec()), fmt(exp_vec()));
      end
      if (fetch_stall === 1'b1) stalls++;
      if (m_idle() && !e_busy) begin done = 1; break; end
    end
    checks++;
    if (!done || stalls != int'(len) + 1) begin
      errors++;
      $display("FAIL starvation_stalls: got %0d stalls done=%0d, expected %0d", stalls, done, int'(len) + 1);
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    bit done = 0;
    step(0, '0, 1, 13'h0123, 8'd5);
    for (int c = 1; c < 30; c++) begin
      step(c == 2 || c == 5, ADDR_W'($urandom), c == 3 || c == 7, 13'h0ABC, 8'd20);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL ignore_start cyc %0d: got %s, expected %s", c, fmt(obs_vec()), fmt(exp_vec()));
      end
      if (dbg_valid === 1'b1) pulses++;
      if (m_idle() && !e_busy) begin done = 1; break; end
    end
    checks++;
    if (!done || pulses != 6) begin
      errors++;
      $display("FAIL ignore_start_count: got %0d dbg_valid done=%0d, expected 6", pulses, done);
    end
  endtask

  task automatic test_max_len();
    int pulses = 0;
    bit done = 0;
    step(0, '0, 1, ADDR_W'($urandom), 8'd255);
    for (int c = 1; c < 1500; c++) begin
      step(1'($urandom_range(0, 1)), ADDR_W'($urandom), 0, '0, '0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL max_len cyc %0d: got %s, expected %s", c, fmt(obs_vec()), fmt(exp_vec()));
      end
      if (dbg_valid === 1'b1) pulses++;
      if (m_idle() && !e_busy) begin done = 1; break; end
    end
    checks++;
    if (!done || pulses != 256) begin
      errors++;
      $display("FAIL max_len_count: got %0d dbg_valid done=%0d, expected 256", pulses, done);
    end
  endtask

  task automatic test_random();
    bit done = 0;
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 99) < 60, ADDR_W'($urandom), $urandom_range(0, 19) == 0,
           ADDR_W'($urandom), LEN_W'($urandom_range(0, 31)));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d: got %s, expected %s", c, fmt(obs_vec()), fmt(exp_vec()));
      end
    end
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 1) == 1, ADDR_W'($urandom), 0, '0, '0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_tail cyc %0d: got %s, expected %s", c, fmt(obs_vec()), fmt(exp_vec()));
      end
      if (m_idle() && !e_busy) begin done = 1; break; end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL random_drain: got busy after bound, expected idle");
    end
  endtask

  task automatic test_reset_mid_burst();
    int late_dv = 0;
    bit done = 0;
    step(0, '0, 1, ADDR_W'($urandom), 8'd15);
    for (int c = 0; c < 6; c++) step(0, '0, 0, '0, '0);
    #2 ponrst_n = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 45'd0) begin
      errors++;
      $display("FAIL reset_mid_burst: got %s, expected all zero", fmt(obs_vec()));
    end
    @(posedge clk);
    #2 ponrst_n = 1'b1;
    m_reset();
    for (int c = 0; c < 15; c++) begin
      step(0, '0, 0, '0, '0);
      if (dbg_valid !== 1'b0 || dbg_busy !== 1'b0) late_dv++;
    end
    checks++;
    if (late_dv != 0) begin
      errors++;
      $display("FAIL reset_abort: got %0d cycles with dbg activity, expected 0", late_dv);
    end
    step(0, '0, 1, ADDR_W'($urandom), LEN_W'($urandom_range(0, 7)));
    for (int c = 1; c < 40; c++) begin
      step($urandom_range(0, 1) == 1, ADDR_W'($urandom), 0, '0, '0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_restart cyc %0d: got %s, expected %s", c, fmt(obs_vec()), fmt(exp_vec()));
      end
      if (m_idle() && !e_busy) begin done = 1; break; end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL reset_restart_drain: got busy after bound, expected idle");
    end
  endtask

`ifdef ROMARB_ACCESS_COUNT_EN
  task automatic test_counters();
    bit fr_pat [10] = '{0, 1, 1, 1, 1, 1, 0, 0, 1, 0};
    ponrst_n = 1'b0;
    fetch_req = 0; dbg_start = 0;
    @(posedge clk);
    #2 ponrst_n = 1'b1;
    m_reset();
    for (int c = 0; c < 10; c++) begin
      step(fr_pat[c], ADDR_W'($urandom), c == 0, ADDR_W'($urandom), 8'd2);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL counters_seq cyc %0d: got %s, expected %s", c, fmt(obs_vec()), fmt(exp_vec()));
      end
    end
    checks++;
    if (fetch_cnt !== 16'd5 || dbg_cnt !== 16'd3 || stall_cnt !== 16'd1 ||
        fetch_cnt !== m_fcnt || dbg_cnt !== m_dcnt || stall_cnt !== m_scnt) begin
      errors++;
      $display("FAIL counters: got f=%0d d=%0d s=%0d, expected f=5 d=3 s=1", fetch_cnt, dbg_cnt, stall_cnt);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 8192; i++) rom_mem[i] = DATA_W'($urandom);
    ponrst_n = 1'b1;
    fetch_req = 0; fetch_addr = '0; dbg_start = 0; dbg_addr = '0; dbg_len = '0;
    m_reset();
    #3;
    test_reset();
    test_fetch_only();
    test_dbg_wrap();
    test_starvation();
    test_ignore_start();
    test_max_len();
    test_random();
    test_reset_mid_burst();
`ifdef ROMARB_ACCESS_COUNT_EN
    test_counters();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
